// File: rtl/regfile_pkg.sv
// Shared constants and decode helper for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREGS_DEF  = 8;
    // Upper bound on register count; callers truncate the decode to their own NREGS.
    localparam int NREGS_MAX  = 256;

    function automatic logic [NREGS_MAX-1:0] onehot_dec(input int unsigned num);
        return NREGS_MAX'(1) << num;
    endfunction

endpackage

// File: rtl/regfile_entry.sv
// One register-file slot: a data word plus its busy bit.
module regfile_entry #(
    parameter int DATA_W   = 16,
    parameter bit TIE_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    input  logic              set,
    output logic [DATA_W-1:0] q,
    output logic              busy
);

    // A tied-off slot is held clear every cycle, so it never stores data or goes busy.
    always_ff @(posedge clk) begin
        if (reset || TIE_ZERO) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            if (load) begin
                q <= data_in;
            end
            // A reservation in the same cycle as the write names a newer producer.
            if (set) begin
                busy <= 1'b1;
            end else if (load) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Register file with one write port, two read ports, optional bypass/zero register and busy tracking.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int   DATA_W  = DATA_W_DEF,
    parameter int   NREGS   = NREGS_DEF,
    parameter int   BYPASS  = 0,
    parameter int   ZERO_R0 = 0,
    localparam int  NUM_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [NUM_W-1:0]  writenum,
    input  logic              write,
    input  logic [NUM_W-1:0]  readnum_a,
    input  logic [NUM_W-1:0]  readnum_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              rsv,
    input  logic [NUM_W-1:0]  rsvnum,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy
);

    logic [NREGS-1:0]  wr_dec;
    logic [NREGS-1:0]  rsv_dec;
    logic [NREGS-1:0]  busy;
    logic [DATA_W-1:0] regs [NREGS];

    assign wr_dec  = NREGS'(onehot_dec(32'(writenum)));
    assign rsv_dec = NREGS'(onehot_dec(32'(rsvnum)));

    for (genvar i = 0; i < NREGS; i++) begin : g_ent
        regfile_entry #(
            .DATA_W   (DATA_W),
            .TIE_ZERO ((ZERO_R0 != 0) && (i == 0))
        ) u_entry (
            .clk     (clk),
            .reset   (reset),
            .data_in (data_in),
            .load    (write & wr_dec[i]),
            .set     (rsv & rsv_dec[i]),
            .q       (regs[i]),
            .busy    (busy[i])
        );
    end

    // The zero register overrides the bypass, since writes to R0 never land.
    function automatic logic [DATA_W-1:0] read_port(input logic [NUM_W-1:0] num);
        if ((ZERO_R0 != 0) && (num == '0)) begin
            return '0;
        end else if ((BYPASS != 0) && write && (writenum == num)) begin
            return data_in;
        end else begin
            return regs[num];
        end
    endfunction

    always_comb begin
        data_out_a = read_port(readnum_a);
        data_out_b = read_port(readnum_b);
    end

    assign busy_a   = busy[readnum_a];
    assign busy_b   = busy[readnum_b];
    assign any_busy = |busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations are queued by the stimulus and checked by a monitor.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Shared stimulus for the three 8x16 instances.
    logic [15:0] d;
    logic [2:0]  wn, ra, rb, rn;
    logic        w, rv;

    // Stimulus for the 16x32 instance.
    logic [31:0] wd;
    logic [3:0]  wwn, wra, wrb, wrn;
    logic        ww, wrv;

    logic [15:0] base_a, base_b, byp_a, byp_b, zero_a, zero_b;
    logic        base_ba, base_bb, base_any;
    logic        byp_ba, byp_bb, byp_any;
    logic        zero_ba, zero_bb, zero_any;
    logic [31:0] wide_a, wide_b;
    logic        wide_ba, wide_bb, wide_any;

    regfile_mp u_base (
        .clk(clk), .reset(reset), .data_in(d), .writenum(wn), .write(w),
        .readnum_a(ra), .readnum_b(rb), .data_out_a(base_a), .data_out_b(base_b),
        .rsv(rv), .rsvnum(rn), .busy_a(base_ba), .busy_b(base_bb), .any_busy(base_any)
    );

    regfile_mp #(.BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .data_in(d), .writenum(wn), .write(w),
        .readnum_a(ra), .readnum_b(rb), .data_out_a(byp_a), .data_out_b(byp_b),
        .rsv(rv), .rsvnum(rn), .busy_a(byp_ba), .busy_b(byp_bb), .any_busy(byp_any)
    );

    regfile_mp #(.BYPASS(1), .ZERO_R0(1)) u_zero (
        .clk(clk), .reset(reset), .data_in(d), .writenum(wn), .write(w),
        .readnum_a(ra), .readnum_b(rb), .data_out_a(zero_a), .data_out_b(zero_b),
        .rsv(rv), .rsvnum(rn), .busy_a(zero_ba), .busy_b(zero_bb), .any_busy(zero_any)
    );

    regfile_mp #(.DATA_W(32), .NREGS(16)) u_wide (
        .clk(clk), .reset(reset), .data_in(wd), .writenum(wwn), .write(ww),
        .readnum_a(wra), .readnum_b(wrb), .data_out_a(wide_a), .data_out_b(wide_b),
        .rsv(wrv), .rsvnum(wrn), .busy_a(wide_ba), .busy_b(wide_bb), .any_busy(wide_any)
    );

    // Observation selectors: instance * 5 + field.
    localparam int BASE = 0, BYP = 5, ZERO = 10, WIDE = 15;
    localparam int F_A = 0, F_B = 1, F_BA = 2, F_BB = 3, F_ANY = 4;

    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            BASE + F_A:   return 32'(base_a);
            BASE + F_B:   return 32'(base_b);
            BASE + F_BA:  return 32'(base_ba);
            BASE + F_BB:  return 32'(base_bb);
            BASE + F_ANY: return 32'(base_any);
            BYP + F_A:    return 32'(byp_a);
            BYP + F_B:    return 32'(byp_b);
            BYP + F_BA:   return 32'(byp_ba);
            BYP + F_BB:   return 32'(byp_bb);
            BYP + F_ANY:  return 32'(byp_any);
            ZERO + F_A:   return 32'(zero_a);
            ZERO + F_B:   return 32'(zero_b);
            ZERO + F_BA:  return 32'(zero_ba);
            ZERO + F_BB:  return 32'(zero_bb);
            ZERO + F_ANY: return 32'(zero_any);
            WIDE + F_A:   return wide_a;
            WIDE + F_B:   return wide_b;
            WIDE + F_BA:  return 32'(wide_ba);
            WIDE + F_BB:  return 32'(wide_bb);
            default:      return 32'(wide_any);
        endcase
    endfunction

    // Monitor: outputs are settled half a period after the inputs change.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [31:0] e, g;
            int          s;
            string       nm;
            e  = exp_q.pop_front();
            s  = sel_q.pop_front();
            nm = name_q.pop_front();
            g  = obs(s);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", nm, g, e);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] val, input string nm);
        exp_q.push_back(val);
        sel_q.push_back(sel);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic w_i, input logic [2:0] wn_i, input logic [15:0] d_i,
                       input logic rv_i, input logic [2:0] rn_i,
                       input logic [2:0] ra_i, input logic [2:0] rb_i);
        w = w_i; wn = wn_i; d = d_i; rv = rv_i; rn = rn_i; ra = ra_i; rb = rb_i;
    endtask

    task automatic wdrv(input logic w_i, input logic [3:0] wn_i, input logic [31:0] d_i,
                        input logic rv_i, input logic [3:0] rn_i,
                        input logic [3:0] ra_i, input logic [3:0] rb_i);
        ww = w_i; wwn = wn_i; wd = d_i; wrv = rv_i; wrn = rn_i; wra = ra_i; wrb = rb_i;
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 16'h0, 0, 0, 0, 0);
        wdrv(0, 0, 32'h0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        chk(BASE + F_A, 0, "reset base a");
        chk(BASE + F_B, 0, "reset base b");
        chk(BASE + F_ANY, 0, "reset base any");
        chk(ZERO + F_ANY, 0, "reset zero any");
        chk(WIDE + F_A, 0, "reset wide a");
        chk(WIDE + F_ANY, 0, "reset wide any");

        drv(1, 3, 16'h1234, 0, 0, 3, 0);
        chk(BASE + F_A, 0, "no bypass R3");
        chk(BYP + F_A, 32'h1234, "bypass R3");
        step();
        drv(1, 5, 16'hBEEF, 0, 0, 3, 5);
        chk(BASE + F_A, 32'h1234, "read R3");
        chk(BASE + F_B, 0, "no bypass R5");
        chk(BYP + F_B, 32'hBEEF, "bypass R5 port b");
        step();
        drv(0, 0, 16'h0, 0, 0, 3, 5);
        chk(BASE + F_A, 32'h1234, "read a R3");
        chk(BASE + F_B, 32'hBEEF, "read b R5");
        step();
        drv(0, 0, 16'h0, 0, 0, 5, 5);
        chk(BASE + F_A, 32'hBEEF, "same reg a");
        chk(BASE + F_B, 32'hBEEF, "same reg b");
        chk(BYP + F_A, 32'hBEEF, "bypass inst stored R5");
        step();

        drv(1, 2, 16'h00AA, 0, 0, 2, 0);
        chk(BASE + F_A, 0, "R2 old value");
        chk(BYP + F_A, 32'h00AA, "R2 bypass");
        step();
        drv(0, 0, 16'h0, 0, 0, 2, 0);
        chk(BASE + F_A, 32'h00AA, "R2 after edge");
        step();

        drv(0, 0, 16'h0, 1, 4, 4, 0);
        chk(BASE + F_BA, 0, "rsv no same-cycle busy");
        chk(BASE + F_ANY, 0, "rsv no same-cycle any");
        step();
        drv(1, 4, 16'h1111, 0, 0, 4, 0);
        chk(BASE + F_BA, 1, "R4 busy");
        chk(BASE + F_ANY, 1, "R4 any busy");
        chk(BYP + F_BA, 1, "busy not bypassed");
        chk(BYP + F_A, 32'h1111, "R4 bypass data");
        chk(BASE + F_A, 0, "R4 old data");
        step();
        drv(1, 4, 16'h2222, 1, 4, 4, 0);
        chk(BASE + F_BA, 0, "R4 busy cleared by write");
        chk(BASE + F_ANY, 0, "any cleared");
        chk(BASE + F_A, 32'h1111, "R4 data");
        step();
        drv(0, 0, 16'h0, 0, 0, 4, 4);
        chk(BASE + F_BA, 1, "rsv wins over write a");
        chk(BASE + F_BB, 1, "rsv wins over write b");
        chk(BASE + F_A, 32'h2222, "R4 new data with rsv");
        chk(BASE + F_ANY, 1, "any after rsv+write");
        step();

        drv(1, 0, 16'hFFFF, 1, 0, 0, 4);
        chk(ZERO + F_A, 0, "zero R0 no bypass");
        chk(BYP + F_A, 32'hFFFF, "R0 bypass without zero");
        chk(BASE + F_A, 0, "R0 before write");
        step();
        drv(0, 0, 16'h0, 0, 0, 0, 0);
        chk(ZERO + F_A, 0, "zero R0 after write");
        chk(ZERO + F_BA, 0, "zero R0 never busy");
        chk(ZERO + F_B, 0, "zero R0 port b");
        chk(BASE + F_A, 32'hFFFF, "R0 written normally");
        chk(BASE + F_BA, 1, "R0 reserved normally");
        step();
        drv(1, 7, 16'h8001, 0, 0, 0, 7);
        chk(ZERO + F_B, 32'h8001, "zero inst R7 bypass");
        chk(BASE + F_B, 0, "R7 before edge");
        step();
        drv(0, 0, 16'h0, 1, 1, 0, 7);
        chk(ZERO + F_B, 32'h8001, "zero inst R7 stored");
        chk(BASE + F_B, 32'h8001, "R7 stored");
        step();

        drv(0, 0, 16'h0, 1, 6, 1, 6);
        chk(BASE + F_BA, 1, "R1 busy");
        chk(BASE + F_BB, 0, "R6 not yet busy");
        step();
        drv(1, 6, 16'h5555, 0, 0, 1, 6);
        chk(BASE + F_BB, 1, "R6 busy");
        chk(BYP + F_B, 32'h5555, "R6 bypass");
        step();
        reset = 1'b1;
        drv(1, 1, 16'h7777, 0, 0, 1, 6);
        chk(BASE + F_A, 0, "R1 never written");
        chk(BASE + F_B, 32'h5555, "R6 before reset");
        chk(BASE + F_BB, 0, "R6 busy cleared by write");
        chk(BASE + F_ANY, 1, "any before reset");
        step();
        reset = 1'b0;
        drv(0, 0, 16'h0, 0, 0, 1, 6);
        chk(BASE + F_A, 0, "R1 after mid reset");
        chk(BASE + F_B, 0, "R6 after mid reset");
        chk(BASE + F_ANY, 0, "base any after reset");
        chk(BYP + F_A, 0, "byp R1 after reset");
        chk(BYP + F_ANY, 0, "byp any after reset");
        chk(ZERO + F_ANY, 0, "zero any after reset");
        step();
        drv(0, 0, 16'h0, 0, 0, 4, 7);
        chk(BASE + F_A, 0, "R4 after reset");
        chk(BASE + F_B, 0, "R7 after reset");
        step();

        for (int i = 0; i < 16; i++) begin
            wdrv(1, 4'(i), 32'(i) * 32'h0101_0101, 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            wdrv(0, 0, 32'h0, 0, 0, 4'(i), 4'(15 - i));
            chk(WIDE + F_A, 32'(i) * 32'h0101_0101, $sformatf("wide a R%0d", i));
            chk(WIDE + F_B, 32'(15 - i) * 32'h0101_0101, $sformatf("wide b R%0d", 15 - i));
            step();
        end
        wdrv(1, 15, 32'hDEAD_BEEF, 1, 3, 15, 0);
        chk(WIDE + F_A, 32'h0F0F_0F0F, "wide R15 old");
        step();
        wdrv(0, 0, 32'h0, 0, 0, 15, 3);
        chk(WIDE + F_A, 32'hDEAD_BEEF, "wide R15 rewrite");
        chk(WIDE + F_BB, 1, "wide R3 busy");
        chk(WIDE + F_BA, 0, "wide R15 not busy");
        chk(WIDE + F_ANY, 1, "wide any busy");
        step();

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
